// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the unified instruction/data memory arbiter:
//   - arb_state_e : arbiter FSM states (IDLE, BUSY, RESP)
//   - OWN_IF/OWN_DM : encoding of the 'owner' output (0 = fetch, 1 = data)
//   - DEF_ADDR_W/DEF_DATA_W : default bus widths of the RV32I core
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 32;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter_if
// Bundles the fetch port, the data port and the single-port memory bus that
// the arbiter connects together, plus the owner/timeout status lines.
//   slave  : the arbiter's view (takes if_*/dm_* requests and memory
//            responses, drives acks, read data, mem_* and status)
//   master : the surrounding system's view (pipeline stages + memory)
// Signals:
//   if_req/if_addr -> if_rdata/if_ack            fetch port
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ack   data port
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ready  memory bus
//   owner, timeout                               status
// ---------------------------------------------------------------------------
interface unified_mem_arbiter_if
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  // Data port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  // Unified memory bus
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Status
  logic              owner;
  logic              timeout;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output owner, timeout
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  owner, timeout
  );

endinterface

// File: rtl/unified_mem_arbiter_wait_counter.sv
// ---------------------------------------------------------------------------
// arb_wait_counter
// Saturating up-counter with a single limit indication.
//   clk, reset  : clock, synchronous active-high reset
//   clr_i       : clear the count (has priority over inc_i)
//   inc_i       : count one event, saturating at LIMIT
//   at_limit_o  : STICKY=1 -> flag that sets when the count reaches LIMIT and
//                             holds until reset (clr_i does not clear it)
//                 STICKY=0 -> high while the count equals LIMIT
// Used as the memory wait counter (sticky timeout) and as the fetch
// starvation counter (level indication).
// ---------------------------------------------------------------------------
module arb_wait_counter #(
  parameter int LIMIT  = 255,
  parameter bit STICKY = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (STICKY) begin : g_sticky
      logic flag_q;
      // Sets on the same edge the count lands on LIMIT, so the flag is
      // visible right after the LIMIT-th counted event.
      always_ff @(posedge clk) begin
        if (reset) begin
          flag_q <= 1'b0;
        end else if (cnt_d == LIM) begin
          flag_q <= 1'b1;
        end
      end
      assign at_limit_o = flag_q;
    end else begin : g_level
      assign at_limit_o = (cnt_q == LIM);
    end
  endgenerate

endmodule

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port memory between the IF-stage fetch port and the
// MEM-stage data port of the 5-stage RV32I pipeline. One access is in flight
// at a time; a req/ack handshake absorbs variable memory latency. The
// pipeline stalls a port while req & ~ack.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset (aborts any access silently)
//   bus    : unified_mem_arbiter_if.slave (fetch port, data port, memory
//            bus, owner and timeout status); all outputs are registered
//
// FSM: IDLE (arbitrate) -> BUSY (memory access held) -> RESP (one-cycle ack)
// -> IDLE. Data has fixed priority over fetch.
//
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
// data grants made while fetch was waiting, the next arbitration goes to
// fetch. Without the macro, strict data priority and no counter.
// ---------------------------------------------------------------------------
module unified_mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 255
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input logic                   clk,
  input logic                   reset,
  unified_mem_arbiter_if.slave  bus
);

  arb_state_e        state_q;
  logic              owner_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic              timeout_q;

  logic grant_dm;
  logic grant_if;
  logic force_if;

  // Arbitration is only meaningful in IDLE; req levels elsewhere are ignored.
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state_q == IDLE) begin
      if (bus.dm_req && !force_if) begin
        grant_dm = 1'b1;
      end else if (bus.if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  // Memory wait counter: counts BUSY cycles without mem_ready, restarts on
  // every grant; the sticky flag is the diagnostic timeout.
  arb_wait_counter #(
    .LIMIT  (MAX_WAIT),
    .STICKY (1'b1)
  ) u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (grant_dm | grant_if),
    .inc_i      ((state_q == BUSY) && !bus.mem_ready),
    .at_limit_o (timeout_q)
  );

`ifdef ARB_STARVE_GUARD_EN
  logic starve_at_limit;

  // Counts data grants that overtook a waiting fetch; any fetch grant
  // restarts it.
  arb_wait_counter #(
    .LIMIT  (STARVE_LIMIT),
    .STICKY (1'b0)
  ) u_starve_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (grant_if),
    .inc_i      (grant_dm & bus.if_req),
    .at_limit_o (starve_at_limit)
  );

  assign force_if = starve_at_limit & bus.if_req;
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; they are only set on BUSY -> RESP.
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_dm) begin
            owner_q     <= OWN_DM;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            mem_req_q   <= 1'b1;
            state_q     <= BUSY;
          end else if (grant_if) begin
            owner_q     <= OWN_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            mem_req_q   <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          // mem_* stay latched here; requester-side changes are ignored.
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (owner_q == OWN_DM) begin
              dm_ack_q <= 1'b1;
              // A store returns no data; keep the last load result.
              if (!mem_we_q) begin
                dm_rdata_q <= bus.mem_rdata;
              end
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.owner     = owner_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage RV32I pipeline.
- Replaces the separate instruction and data memories.
- Serialises accesses with a req/ack handshake and tolerates variable memory latency.
- The pipeline uses `req & ~ack` on each port as its stall condition.

Parameters:
- ADDR_W, 20, byte-address width (matches the 20-bit PC/data address space)
- DATA_W, 32, word width
- MAX_WAIT, 255, memory wait cycles before the sticky timeout flag sets
- STARVE_LIMIT, 4, consecutive data grants before fetch is forced (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction; valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data, already width-controlled
- dm_rdata  out  DATA_W  load data; valid while dm_ack=1
- dm_ack  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory access valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready
- mem_ready  in  1  memory completes the access this cycle
- owner  out  1  current grant: 0 = fetch, 1 = data
- timeout  out  1  sticky error flag

Behaviour:
- Reset values: every output is 0, the state is IDLE, all counters are 0.
- Reset mid-access aborts the access silently; no ack is issued.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If dm_req=1, grant data, even when if_req=1 (data has fixed priority).
  - Otherwise, if if_req=1, grant fetch.
  - On a grant: latch owner, address, we and wdata; drive mem_req=1 from the next cycle; go to BUSY.
  - With no request, stay in IDLE with mem_req=0.
- BUSY:
  - mem_req and the latched mem_* signals are held constant.
  - When mem_ready=1: capture mem_rdata into the owner's rdata register (dm_rdata keeps its old value on a store), assert that owner's ack next cycle, deassert mem_req, go to RESP.
  - Otherwise increment wait_cnt.
  - When wait_cnt reaches MAX_WAIT, timeout sets and holds until reset. The FSM keeps waiting; timeout is diagnostic only.
- RESP:
  - The ack is high for exactly this one cycle; rdata stays stable this cycle.
  - Return to IDLE unconditionally.
  - Requesters deassert or change req after observing ack; the arbiter ignores req levels in RESP.
- Latency: with mem_ready in the first BUSY cycle, ack arrives 2 cycles after the request is sampled. Minimum spacing between grants is 3 cycles.
- Inputs are sampled only in IDLE. Changes to if_addr/dm_* during BUSY do not affect the access in flight.
- if_ack and dm_ack are never high in the same cycle.
- wait_cnt saturates at MAX_WAIT and clears on every grant.
- mem_ready seen while not in BUSY is ignored.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter tracks consecutive data grants made while if_req=1, saturating at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT, the next IDLE arbitration grants fetch if if_req=1, regardless of dm_req.
  - The counter clears on any fetch grant or reset.
- Undefined: strict data priority; no counter logic is present.

Decomposition:
- Shared package `rv32i_pkg` holds:
  - arbiter state enum (IDLE, BUSY, RESP)
  - owner encoding constants (OWN_IF = 0, OWN_DM = 1)
  - default ADDR_W/DATA_W constants
- One natural sub-module: `arb_wait_counter`, a saturating wait counter plus sticky timeout, reused for the starve counter.
- The FSM and datapath latches stay in the top module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x00010, mem_ready 1 cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x00010, mem_we=0; if_ack pulses 2 cycles after request; if_rdata=0x00500093.
- Contention: if_req=1 and dm_req=1 (load, 0x00100) in the same cycle -> data granted first and dm_ack pulses; fetch granted on the next IDLE; if_ack follows 3 cycles after dm_ack.
- Store: dm_req=1, dm_we=1, dm_addr=0x00200, dm_wdata=0xDEADBEEF, mem_ready after 3 wait cycles -> mem_we=1, mem_wdata=0xDEADBEEF held stable for 4 cycles; single dm_ack; dm_rdata unchanged.
- Timeout: with MAX_WAIT=8, hold mem_ready=0 for 10 cycles -> timeout=1 after the 8th wait cycle; then mem_ready=1 -> normal ack; timeout stays 1 until reset.
- Reset mid-access: assert reset during BUSY -> next cycle mem_req=0, acks 0, owner=0; a later fetch completes normally.
- ARB_STARVE_GUARD_EN, STARVE_LIMIT=4: dm_req and if_req held continuously -> grant order DM, DM, DM, DM, IF, DM...
